house_visit_scheduler: RTL and testbench
========================================

HOUSE_VISIT_SCHEDULER -- requirements
Module: house_visit_scheduler

Interface
REQ-001 SHALL have parameter POSITION_WIDTH, default 16, width of the signed two's-complement pos_x/pos_y.
REQ-002 SHALL have parameter MAP_WIDTH, default 6, low-order bits per coordinate used to address the visited map (MAP_WIDTH <= POSITION_WIDTH).
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, position queue entries (power of two).
REQ-004 SHALL have parameter COUNT_WIDTH, default 16, width of unique_count.
REQ-005 SHALL have ports, in this order:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- pos_change  in  1  pos_x/pos_y valid this cycle
- pos_x  in  POSITION_WIDTH  agent x
- pos_y  in  POSITION_WIDTH  agent y
- input_done  in  1  pulse: no further pos_change follows
- ready  out  1  map clear complete; upstream may stream
- mem_en  out  1  map port access strobe
- mem_we  out  1  write when mem_en=1
- mem_addr  out  2*MAP_WIDTH  {pos_x[MAP_WIDTH-1:0], pos_y[MAP_WIDTH-1:0]}
- mem_wdata  out  1  visited bit to write
- mem_rdata  in  1  read data, valid the cycle after a read strobe
- fifo_overflow  out  1  sticky: a position was dropped
- unique_count  out  COUNT_WIDTH  distinct houses visited
- result_valid  out  1  unique_count is final

Function
REQ-006 SHALL implement FSM states CLEAR, IDLE, LOOKUP, UPDATE, DONE.
REQ-007 CLEAR SHALL write 0 to map addresses 0 .. 2^(2*MAP_WIDTH)-1, one per cycle in ascending order, then go to IDLE.
REQ-008 ready SHALL be 0 in CLEAR and 1 from the first IDLE cycle until reset.
REQ-009 Every pos_change cycle SHALL push {pos_x, pos_y} into the FIFO in all states except DONE, including CLEAR.
REQ-010 A push when the FIFO is full SHALL drop that position and set fifo_overflow.
REQ-011 A pop in the same cycle as a push on a full FIFO SHALL accept the push without overflow.
REQ-012 IDLE with the FIFO non-empty SHALL pop the head and go to LOOKUP.
REQ-013 LOOKUP SHALL drive mem_en=1, mem_we=0 and mem_addr of the popped position, then go to UPDATE.
REQ-014 In UPDATE, if mem_rdata=0, the block SHALL drive mem_en=1, mem_we=1, mem_wdata=1 to the same address and increment unique_count.
REQ-015 If mem_rdata=1 in UPDATE, the block SHALL issue no access and leave the count unchanged.
REQ-016 UPDATE SHALL go to LOOKUP, popping in the same cycle, if the FIFO is non-empty; otherwise to IDLE.
REQ-017 Throughput SHALL be one position per 2 cycles.
REQ-018 A read issued the cycle after a write to the same address SHALL observe the written value; no forwarding is needed.
REQ-019 unique_count SHALL saturate at 2^COUNT_WIDTH-1.
REQ-020 Coordinates SHALL be truncated to MAP_WIDTH bits (modulo aliasing), so negative coordinates wrap.
REQ-021 input_done SHALL set a sticky done_seen flag in any state.
REQ-022 The block SHALL go to DONE from IDLE when done_seen=1 and the FIFO is empty.
REQ-023 DONE SHALL hold result_valid=1 and unique_count stable, ignore pos_change, and persist until reset.
REQ-024 mem_en SHALL be 0 in IDLE and DONE.

Reset
REQ-025 Reset SHALL enter CLEAR at clear address 0 and empty the FIFO.
REQ-026 Reset SHALL clear unique_count, fifo_overflow, done_seen, result_valid and ready to 0.
REQ-027 Reset asserted mid-operation, in any state, SHALL abandon the in-flight position and restart the full clear sweep.

Structure
REQ-028 The FSM state enum and a map address width function SHALL live in a shared package with the project's direction typedefs.
REQ-029 The FIFO SHALL be a separate sub-module, position_fifo (parameters DATA_WIDTH, DEPTH; push/pop/full/empty), instantiated once.

Verification
REQ-030 MAP_WIDTH=2, no input: ready rises after exactly 16 clear writes to addresses 0..15, mem_we=1, mem_wdata=0.
REQ-031 After ready, positions (0,0),(0,1),(0,-1) then input_done: unique_count=3, result_valid=1.
REQ-032 After ready, (0,0) sent 5 times back-to-back then input_done: unique_count=1, exactly one map write.
REQ-033 MAP_WIDTH=4, positions (0,0),(16,0),(-16,0): unique_count=1 (aliasing).
REQ-034 FIFO_DEPTH=8, 9 consecutive pos_change during CLEAR: fifo_overflow=1; final count reflects the first 8 only.
REQ-035 Reset pulsed during UPDATE: ready=0, count=0, clear sweep restarts at address 0; a subsequent (0,0),(1,0) stream yields count 2.

Source files
------------

// File: rtl/house_visit_scheduler_pkg.sv
// house_visit_scheduler_pkg: shared FSM state, direction typedefs and map address width helper
package house_visit_scheduler_pkg;
  typedef enum logic [2:0] {CLEAR, IDLE, LOOKUP, UPDATE, DONE} state_t;
  typedef enum logic [1:0] {DIR_NORTH, DIR_EAST, DIR_SOUTH, DIR_WEST} dir_t;
  function automatic int map_addr_width(input int map_width);
    return 2 * map_width;
  endfunction
endpackage

// File: rtl/house_visit_scheduler_position_fifo.sv
// position_fifo: synchronous FIFO holding truncated positions awaiting a map lookup
// Ports: clk, reset (sync, active-high), push/wdata enqueue, pop dequeues the head,
// rdata shows the current head, full/empty report occupancy.
// A push on a full FIFO is accepted when a pop frees an entry in the same cycle.
module position_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty
);
  localparam int PW = $clog2(DEPTH);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  logic do_push, do_pop;
  always_comb begin
    full = count == (PW+1)'(DEPTH);
    empty = count == '0;
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    rdata = mem[rd_ptr];
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + PW'(1) : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + PW'(1) : rd_ptr;
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/house_visit_scheduler.sv
// house_visit_scheduler: counts distinct houses visited using an external 1-bit visited map
// Ports: clk, reset (sync, active-high); pos_change/pos_x/pos_y stream agent positions;
// input_done marks end of stream; ready rises once the map clear sweep finishes;
// mem_en/mem_we/mem_addr/mem_wdata/mem_rdata drive the map (read data one cycle late);
// fifo_overflow is sticky on a dropped position; unique_count/result_valid give the answer.
module house_visit_scheduler
  import house_visit_scheduler_pkg::*;
#(
  parameter int POSITION_WIDTH = 16,
  parameter int MAP_WIDTH = 6,
  parameter int FIFO_DEPTH = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          pos_change,
  input  logic signed [POSITION_WIDTH-1:0] pos_x,
  input  logic signed [POSITION_WIDTH-1:0] pos_y,
  input  logic                          input_done,
  output logic                          ready,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [2*MAP_WIDTH-1:0]        mem_addr,
  output logic                          mem_wdata,
  input  logic                          mem_rdata,
  output logic                          fifo_overflow,
  output logic [COUNT_WIDTH-1:0]        unique_count,
  output logic                          result_valid
);
  localparam int AW = map_addr_width(MAP_WIDTH);
  state_t state;
  logic [AW-1:0] clear_addr, cur_addr, head;
  logic push, pop, full, empty, done_seen;
  always_comb begin
    push = pos_change && state != DONE;
    pop = (state == IDLE || state == UPDATE) && !empty;
    mem_en = state == CLEAR || state == LOOKUP || (state == UPDATE && !mem_rdata);
    mem_we = state == CLEAR || (state == UPDATE && !mem_rdata);
    mem_wdata = state == UPDATE;
    mem_addr = state == CLEAR ? clear_addr : cur_addr;
  end
  // Only the map-addressing bits are queued; higher coordinate bits alias away.
  position_fifo #(.DATA_WIDTH(AW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .wdata({pos_x[MAP_WIDTH-1:0], pos_y[MAP_WIDTH-1:0]}),
    .rdata(head),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      clear_addr <= '0;
      cur_addr <= '0;
      unique_count <= '0;
      fifo_overflow <= 1'b0;
      done_seen <= 1'b0;
      result_valid <= 1'b0;
      ready <= 1'b0;
    end else begin
      if (input_done) done_seen <= 1'b1;
      if (push && full && !pop) fifo_overflow <= 1'b1;
      if (pop) cur_addr <= head;
      case (state)
        CLEAR: begin
          clear_addr <= clear_addr + AW'(1);
          if (&clear_addr) begin
            state <= IDLE;
            ready <= 1'b1;
          end
        end
        IDLE: begin
          if (!empty) state <= LOOKUP;
          else if (done_seen) begin
            state <= DONE;
            result_valid <= 1'b1;
          end
        end
        LOOKUP: state <= UPDATE;
        UPDATE: begin
          // mem_rdata here is the visited bit read during LOOKUP.
          if (!mem_rdata && !(&unique_count)) unique_count <= unique_count + COUNT_WIDTH'(1);
          state <= empty ? IDLE : LOOKUP;
        end
        default: state <= DONE;
      endcase
    end
  end
endmodule

// File: tb/tb_house_visit_scheduler.sv
// tb_house_visit_scheduler: directed and randomized checks of house_visit_scheduler against a set model
module tb_house_visit_scheduler;
  localparam int PW = 16, MW = 2, FD = 8, CW = 4, AW = 2 * MW, NA = 1 << AW;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 0, reset = 1, pos_change = 0, input_done = 0, mem_rdata = 0;
  logic [PW-1:0] pos_x = '0, pos_y = '0;
  logic ready, mem_en, mem_we, mem_wdata, fifo_overflow, result_valid;
  logic [AW-1:0] mem_addr;
  logic [CW-1:0] unique_count;
  logic map [NA] = '{default: 1'b1};
  int clr_n, wr_n, errors = 0, checks = 0, distinct;
  bit clr_bad;
  bit seen [NA];
  always #5 clk = ~clk;
  house_visit_scheduler #(.POSITION_WIDTH(PW), .MAP_WIDTH(MW), .FIFO_DEPTH(FD), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .pos_change(pos_change), .pos_x(pos_x), .pos_y(pos_y),
    .input_done(input_done), .ready(ready), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .fifo_overflow(fifo_overflow), .unique_count(unique_count), .result_valid(result_valid)
  );
  always @(posedge clk) begin
    if (mem_en && mem_we) map[mem_addr] <= mem_wdata;
    else if (mem_en) mem_rdata <= map[mem_addr];
  end
  always @(posedge clk) begin
    if (reset) begin
      clr_n <= 0;
      wr_n <= 0;
      clr_bad <= 0;
    end else if (mem_en && mem_we) begin
      if (!ready) begin
        if (int'(mem_addr) != clr_n || mem_wdata !== 1'b0) clr_bad <= 1;
        clr_n <= clr_n + 1;
      end else wr_n <= wr_n + 1;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic model_clear();
    foreach (seen[i]) seen[i] = 0;
    distinct = 0;
  endtask
  task automatic model_add(input int x, input int y);
    int a;
    a = (((x % 4) + 4) % 4) * 4 + (((y % 4) + 4) % 4);
    if (!seen[a]) distinct++;
    seen[a] = 1;
  endtask
  task automatic do_reset();
    reset = 1;
    pos_change = 0;
    input_done = 0;
    tick(2);
    reset = 0;
    model_clear();
  endtask
  task automatic wait_ready(input string tag);
    int n = 0;
    while (!ready && n < 200) begin
      tick(1);
      n++;
    end
    chk({tag, " ready"}, 32'(ready), 1);
    chk({tag, " clear_writes"}, clr_n, 16);
    chk({tag, " clear_order"}, 32'(clr_bad), 0);
  endtask
  task automatic send(input int x, input int y, input bit count_it);
    pos_change = 1;
    pos_x = PW'(x);
    pos_y = PW'(y);
    tick(1);
    pos_change = 0;
    if (count_it) model_add(x, y);
  endtask
  task automatic finish_run(input string tag);
    int n = 0;
    input_done = 1;
    tick(1);
    input_done = 0;
    while (!result_valid && n < 300) begin
      tick(1);
      n++;
    end
    chk({tag, " result_valid"}, 32'(result_valid), 1);
  endtask
  task automatic expect_result(input string tag, input bit ovf);
    chk({tag, " count"}, 32'(unique_count), distinct > CMAX ? CMAX : distinct);
    chk({tag, " map_writes"}, wr_n, distinct);
    chk({tag, " overflow"}, 32'(fifo_overflow), 32'(ovf));
  endtask
  initial begin
    int w, n;
    reset = 1;
    tick(2);
    chk("reset ready", 32'(ready), 0);
    chk("reset count", 32'(unique_count), 0);
    chk("reset result_valid", 32'(result_valid), 0);
    chk("reset overflow", 32'(fifo_overflow), 0);
    do_reset();
    chk("clear strobe", 32'({mem_en, mem_we, mem_wdata}), 32'b110);
    wait_ready("sweep");
    send(0, 0, 1); send(0, 1, 1); send(0, -1, 1);
    finish_run("three");
    chk("three count", 32'(unique_count), 3);
    expect_result("three", 0);
    w = wr_n;
    send(3, 3, 0);
    tick(6);
    chk("done hold count", 32'(unique_count), 3);
    chk("done hold valid", 32'(result_valid), 1);
    chk("done mem_en", 32'(mem_en), 0);
    chk("done no writes", wr_n, w);
    do_reset();
    wait_ready("repeat");
    repeat (5) send(0, 0, 1);
    finish_run("repeat");
    chk("repeat count", 32'(unique_count), 1);
    expect_result("repeat", 0);
    do_reset();
    wait_ready("alias");
    send(0, 0, 1); send(16, 0, 1); send(-16, 0, 1);
    finish_run("alias");
    chk("alias count", 32'(unique_count), 1);
    expect_result("alias", 0);
    do_reset();
    for (int i = 0; i < 9; i++) send(i % 4, i / 4, i < FD);
    chk("ovf during clear", 32'(ready), 0);
    wait_ready("ovf");
    finish_run("ovf");
    chk("ovf count", 32'(unique_count), 8);
    expect_result("ovf", 1);
    do_reset();
    wait_ready("midreset");
    send(2, 2, 0);
    n = 0;
    while (!(mem_en && !mem_we) && n < 50) begin
      tick(1);
      n++;
    end
    chk("midreset lookup", 32'({mem_en, mem_we}), 32'b10);
    tick(1);
    chk("midreset update write", 32'({mem_en, mem_we, mem_wdata}), 32'b111);
    reset = 1;
    tick(1);
    reset = 0;
    chk("midreset ready", 32'(ready), 0);
    chk("midreset count", 32'(unique_count), 0);
    chk("midreset sweep addr", 32'({mem_en, mem_we, mem_addr}), 32'({2'b11, AW'(0)}));
    model_clear();
    wait_ready("midreset");
    send(0, 0, 1); send(1, 0, 1);
    finish_run("midreset");
    chk("midreset final", 32'(unique_count), 2);
    expect_result("midreset", 0);
    do_reset();
    wait_ready("sat");
    for (int i = 0; i < NA + 3; i++) begin
      send(i % 4, (i / 4) % 4, 1);
      tick(1);
    end
    finish_run("sat");
    chk("sat count", 32'(unique_count), CMAX);
    expect_result("sat", 0);
    for (int r = 0; r < 4; r++) begin
      do_reset();
      wait_ready("rand");
      n = $urandom_range(5, 24);
      for (int i = 0; i < n; i++) begin
        send(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768, 1);
        tick($urandom_range(1, 3));
      end
      finish_run("rand");
      expect_result("rand", 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
